seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter for the FSM library, the sending end of the serial bit-sequence detectors. A Moore state machine that captures a parallel pattern on a start strobe and shifts it out one bit per clock, MSB first, with a programmable length, repeat count and inter-repetition gap. It drives the serial inputs of the detector blocks in loopback benches and in the stimulus path of the top level.

## Interface
- PAT_W, 8, maximum pattern length in bits
- LEN_W, 4, width of the len port; must hold values 0..PAT_W
- CNT_W, 4, width of the reps port
- GAP, 1, idle cycles inserted between repetitions; 0 is legal and means back-to-back
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- abort  input  1  terminate the transfer; sampled in every state
- pat  input  PAT_W  pattern; bits len-1..0 are sent, bit len-1 first
- len  input  LEN_W  number of pattern bits to send
- reps  input  CNT_W  number of repetitions; 0 means continuous until abort
- dout  output  1  serial data bit
- dvalid  output  1  dout carries a pattern bit this cycle
- frame_start  output  1  pulse coinciding with the first bit of each repetition
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the last bit of the last repetition

## Operation
- States: IDLE, SEND, GAP_WAIT, DONE. All outputs are registered Moore outputs decoded from state and counters.
- IDLE: when start=1, abort=0 and len!=0, capture pat, len and reps into internal registers, then go to SEND. Otherwise stay in IDLE.
  - len=0: start is ignored.
  - len>PAT_W: len is clamped to PAT_W.
  - pat, len and reps are not sampled again until the next accepted start.
- SEND: dvalid=1 and dout=captured pat[bit_idx]. bit_idx starts at len-1 and decrements every cycle. After bit 0:
  - If this was the last repetition (rep counter reached reps, reps!=0), go to DONE.
  - Otherwise, if GAP>0, go to GAP_WAIT.
  - Otherwise (GAP=0), reload bit_idx to len-1 and stay in SEND.
- GAP_WAIT: dvalid=0 for exactly GAP cycles, then reload bit_idx and return to SEND.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE. start is ignored while in DONE.
- reps=0: the rep counter never terminates the transfer; it runs until abort.
- Rep counter: CNT_W bits, counts completed repetitions, compared with the captured reps.
- abort=1 in any non-IDLE state: go to IDLE on the next edge. done is not asserted. Partial output is discarded.
- abort=1 and start=1 in IDLE in the same cycle: abort wins and start is ignored.
- start while busy: ignored; no queueing.
- When dvalid=0, dout=0.

## Timing
- Reset (asynchronous): state=IDLE, all counters cleared, and dout=dvalid=frame_start=busy=done=0 immediately, without waiting for a clock edge. Reset mid-transfer drops the transfer; no done is asserted.
- Start latency: start accepted at edge k puts the first bit on dout with dvalid=1 and frame_start=1 during cycle k+1.
- Each bit is held for exactly one cycle. One repetition occupies len cycles followed by GAP idle cycles, except after the final repetition.
- busy=1 from cycle k+1 through the last bit cycle, including gap cycles. busy=0 in DONE.
- done: high in the cycle immediately after the last bit. The block is back in IDLE one cycle later and can accept start then, which is edge k+N+2 for total transmit length N.
- abort sampled at edge m: dvalid=busy=0 from cycle m+1.

## Test plan
- Reset: assert rst asynchronously mid-SEND, between edges -> all outputs read 0 before the next edge; after release, state is IDLE and no done pulse appears.
- Single shot: pat=8'h01, len=3, reps=1, start at edge k -> dout=0,0,1 with dvalid=1 in cycles k+1..k+3; frame_start only at k+1; busy k+1..k+3; done at k+4; a new start is accepted at edge k+5.
- Repeat with gap: pat=8'h01, len=3, reps=3, GAP=1 -> dout stream 0,0,1,-,0,0,1,-,0,0,1 (- means dvalid=0); frame_start at k+1, k+5 and k+9; done at k+12. Re-run with GAP=0 -> 9 contiguous valid bits and done at k+10.
- Continuous and abort: pat=8'hA5, len=8, reps=0, abort asserted at edge k+13 -> bits 1,0,1,0,0,1,0,1 repeat with GAP spacing; dvalid=busy=0 from k+14; done is never asserted.
- Corner inputs: len=0 with start -> nothing happens; len=12 -> exactly 8 bits are sent; start pulsed during SEND and during DONE -> ignored; start+abort together in IDLE -> stays IDLE.
- Loopback: dout/dvalid feed the 001 detector with pat=001, reps=4, GAP=0 -> the detector flags each completed 001 occurrence, 4 flags in total, with no spurious flags in gap cycles.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures pat/len/reps on start and shifts the pattern out MSB first.
// Latency: the first bit appears in the cycle after start is accepted; done follows the last bit by one cycle.
// Backpressure: none. start is honoured only in IDLE, and abort returns the block to IDLE from any state.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        transfer request (IDLE only) / terminate (any state)
//   pat, len, reps      pattern, bit count (clamped to PAT_W), repetitions (0 = continuous)
//   dout, dvalid        serial bit and its qualifier
//   frame_start         high with the first bit of every repetition
//   busy, done          transfer in progress / one-cycle completion pulse
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  output logic             dout,
  output logic             dvalid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  // The gap counter keeps at least one bit so that GAP=0 still elaborates;
  // GAP_WAIT is unreachable in that case.
  localparam int GAP_CW   = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, DONE} state_t;

  state_t state;
  state_t state_nx;

  logic [PAT_W-1:0]  pat_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  reps_q;
  logic [LEN_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  rep_cnt;
  logic [GAP_CW-1:0] gap_cnt;

  logic [LEN_W-1:0]  len_eff;
  logic [PAT_W-1:0]  pat_sh;
  logic              accept;
  logic              last_bit;
  logic              last_rep;

  assign len_eff  = (len > LEN_MAX) ? LEN_MAX : len;
  assign accept   = (state == IDLE) && start && !abort && (len != '0);
  assign last_bit = (bit_idx == '0);
  // rep_cnt counts completed repetitions, so the one now in flight is the
  // last when rep_cnt+1 reaches reps. reps=0 never matches.
  assign last_rep = (reps_q != '0) && ((rep_cnt + CNT_W'(1)) == reps_q);
  // A shift selects the current bit without tying the index width to PAT_W.
  assign pat_sh   = pat_q >> bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and Moore outputs. The outputs depend only on registered
  // state, so reset clears them without waiting for an edge.
  always_comb begin
    state_nx    = state;
    dout        = 1'b0;
    dvalid      = 1'b0;
    frame_start = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SEND;
        end
      end
      SEND: begin
        dvalid      = 1'b1;
        dout        = pat_sh[0];
        frame_start = (bit_idx == (len_q - LEN_W'(1)));
        busy        = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (last_bit) begin
          if (last_rep) begin
            state_nx = DONE;
          end else if (GAP > 0) begin
            state_nx = GAP_WAIT;
          end else begin
            state_nx = SEND;
          end
        end
      end
      GAP_WAIT: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (gap_cnt == GAP_CW'(GAP_LAST)) begin
          state_nx = SEND;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Captured parameters and counters. bit_idx is reloaded at the end of each
  // repetition so that it is ready on entry to SEND, whether the block goes
  // straight back to SEND or through GAP_WAIT first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      bit_idx <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pat_q   <= pat;
            len_q   <= len_eff;
            reps_q  <= reps;
            bit_idx <= len_eff - LEN_W'(1);
            rep_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        SEND: begin
          if (last_bit) begin
            bit_idx <= len_q - LEN_W'(1);
            rep_cnt <= rep_cnt + CNT_W'(1);
            gap_cnt <= '0;
          end else begin
            bit_idx <= bit_idx - LEN_W'(1);
          end
        end
        GAP_WAIT: begin
          gap_cnt <= gap_cnt + GAP_CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pat;
  logic [3:0] len;
  logic [3:0] reps;

  // Index 0 is the GAP=1 instance and index 1 is the GAP=0 instance.
  logic dout_g1, dvalid_g1, fs_g1, busy_g1, done_g1;
  logic dout_g0, dvalid_g0, fs_g0, busy_g0, done_g0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pat(pat), .len(len), .reps(reps),
    .dout(dout_g1), .dvalid(dvalid_g1), .frame_start(fs_g1),
    .busy(busy_g1), .done(done_g1)
  );

  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pat(pat), .len(len), .reps(reps),
    .dout(dout_g0), .dvalid(dvalid_g0), .frame_start(fs_g0),
    .busy(busy_g0), .done(done_g0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each transfer is a timeline indexed by t, the number of
  // cycles since the first bit. A repetition spans len bit cycles plus gap idle
  // cycles, and the done pulse lands at reps*(len+gap)-gap.
  bit         m_act[2];
  int         m_t[2];
  logic [7:0] m_pat[2];
  int         m_len[2];
  int         m_reps[2];

  logic [2:0] hist[2];
  int         flags[2];

  function automatic int gap_of(int gi);
    return (gi == 0) ? 1 : 0;
  endfunction

  // Expected outputs packed as {dvalid, dout, frame_start, busy, done}.
  function automatic logic [4:0] model_out(int gi);
    int p, o, n;
    if (!m_act[gi]) return 5'b00000;
    p = m_len[gi] + gap_of(gi);
    n = m_reps[gi] * p - gap_of(gi);
    if (m_reps[gi] != 0 && m_t[gi] == n) return 5'b00001;
    o = m_t[gi] % p;
    if (o < m_len[gi]) return {1'b1, m_pat[gi][m_len[gi] - 1 - o], (o == 0), 1'b1, 1'b0};
    return 5'b00010;
  endfunction

  task automatic model_edge();
    for (int gi = 0; gi < 2; gi++) begin
      if (rst) begin
        m_act[gi] = 1'b0;
      end else if (!m_act[gi]) begin
        if (start && !abort && len != 0) begin
          m_act[gi]  = 1'b1;
          m_t[gi]    = 0;
          m_pat[gi]  = pat;
          m_len[gi]  = (len > 8) ? 8 : int'(len);
          m_reps[gi] = int'(reps);
        end
      end else if (abort) begin
        m_act[gi] = 1'b0;
      end else if (m_reps[gi] != 0 &&
                   m_t[gi] == m_reps[gi] * (m_len[gi] + gap_of(gi)) - gap_of(gi)) begin
        m_act[gi] = 1'b0;
      end else begin
        m_t[gi]++;
      end
    end
  endtask

  // A small 001 detector on the valid bit stream, standing in for the
  // downstream detector block.
  task automatic detect(int gi, logic v, logic d);
    if (v) begin
      hist[gi] = {hist[gi][1:0], d};
      if (hist[gi] == 3'b001) flags[gi]++;
    end
  endtask

  task automatic compare();
    check("out_gap1", {dvalid_g1, dout_g1, fs_g1, busy_g1, done_g1}, model_out(0));
    check("out_gap0", {dvalid_g0, dout_g0, fs_g0, busy_g0, done_g0}, model_out(1));
    detect(0, dvalid_g1, dout_g1);
    detect(1, dvalid_g0, dout_g0);
  endtask

  // Inputs are applied 1 time unit after an edge, sampled at the next edge,
  // and the outputs are then compared 1 time unit after that edge.
  task automatic step(input logic s, input logic a, input logic [7:0] p,
                      input logic [3:0] l, input logic [3:0] r);
    start = s; abort = a; pat = p; len = l; reps = r;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
  endtask

  initial begin
    for (int gi = 0; gi < 2; gi++) begin
      m_act[gi] = 1'b0; m_t[gi] = 0; m_pat[gi] = '0; m_len[gi] = 0; m_reps[gi] = 0;
      hist[gi] = 3'b111; flags[gi] = 0;
    end
    rst = 1'b1;
    start = 1'b0; abort = 1'b0; pat = '0; len = '0; reps = '0;
    idle(2);
    #1 rst = 1'b0;
    idle(2);

    // Single shot. start is held high so that it is also presented during
    // SEND and DONE, and it is accepted again only once the block is back in IDLE.
    step(1'b1, 1'b0, 8'h01, 4'd3, 4'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h01, 4'd3, 4'd1);
    idle(8);

    // Three repetitions, with a gap on one instance and back-to-back on the other.
    step(1'b1, 1'b0, 8'h01, 4'd3, 4'd3);
    idle(14);

    // Continuous transfer terminated by abort at the 13th edge after start.
    step(1'b1, 1'b0, 8'hA5, 4'd8, 4'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 4'd0, 4'd0);
    step(1'b0, 1'b1, 8'h00, 4'd0, 4'd0);
    idle(4);

    // Corner inputs: len=0, len above PAT_W, and start together with abort.
    step(1'b1, 1'b0, 8'hFF, 4'd0, 4'd1);
    idle(2);
    step(1'b1, 1'b0, 8'h3C, 4'd12, 4'd1);
    idle(11);
    step(1'b1, 1'b1, 8'hFF, 4'd4, 4'd1);
    idle(3);

    // Asynchronous reset between edges in the middle of a transfer.
    step(1'b1, 1'b0, 8'hA5, 4'd8, 4'd1);
    idle(3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gap1", {dvalid_g1, dout_g1, fs_g1, busy_g1, done_g1}, 5'b00000);
    check("async_rst_gap0", {dvalid_g0, dout_g0, fs_g0, busy_g0, done_g0}, 5'b00000);
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(12);

    // Loopback into the 001 detector.
    for (int gi = 0; gi < 2; gi++) begin hist[gi] = 3'b111; flags[gi] = 0; end
    step(1'b1, 1'b0, 8'h01, 4'd3, 4'd4);
    idle(18);
    check("loop_flags_gap1", flags[0], 4);
    check("loop_flags_gap0", flags[1], 4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), 8'($urandom),
           4'($urandom_range(0, 12)), 4'($urandom_range(0, 3)));
    end
    step(1'b0, 1'b1, 8'h00, 4'd0, 4'd0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
